// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared types and constants for the PS/2 key-to-voice-channel allocator.
//   pstate_e     : prefix parser states
//   PFX_EXT      : extended-key prefix byte (E0)
//   PFX_BRK      : break (key release) prefix byte (F0)
//   NUM_CH       : number of voice channels
//   is_ignored() : true for keyboard status/response bytes that carry no key
// ---------------------------------------------------------------------------
package key_pkg;

   typedef enum logic [1:0] {
      P_IDLE,
      P_E0,
      P_F0,
      P_E0F0
   } pstate_e;

   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_BRK = 8'hF0;
   localparam int         NUM_CH  = 4;

   // Self-test pass, ack, echo, resend, buffer-overrun codes: none is a key.
   function automatic logic is_ignored(input logic [7:0] b);
      return (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF});
   endfunction

endpackage

// File: rtl/key_channel_alloc_if.sv
// ---------------------------------------------------------------------------
// key_channel_alloc_if
// Byte-stream input and channel-state output bundle of key_channel_alloc.
//   code_valid   : one-cycle strobe, code_data holds a new PS/2 byte
//   code_data    : PS/2 set-2 byte
//   clr          : synchronous panic clear
//   scan_code1-4 : per-channel key code, or the idle code when free
//   busy_mask    : bit k-1 set while channel k holds a key
//   overflow     : one-cycle pulse, a make arrived with every channel busy
// master drives the byte stream; slave is the allocator.
// ---------------------------------------------------------------------------
interface key_channel_alloc_if;

   logic       code_valid;
   logic [7:0] code_data;
   logic       clr;
   logic [7:0] scan_code1;
   logic [7:0] scan_code2;
   logic [7:0] scan_code3;
   logic [7:0] scan_code4;
   logic [3:0] busy_mask;
   logic       overflow;

   modport master (
      output code_valid, code_data, clr,
      input  scan_code1, scan_code2, scan_code3, scan_code4, busy_mask, overflow
   );

   modport slave (
      input  code_valid, code_data, clr,
      output scan_code1, scan_code2, scan_code3, scan_code4, busy_mask, overflow
   );

endinterface

// File: rtl/ps2_code_parser.sv
// ---------------------------------------------------------------------------
// ps2_code_parser
// Turns the PS/2 set-2 byte stream into make / break events.
//   clk, rst_n  : clock, asynchronous active-low reset
//   code_valid  : new byte strobe
//   code_data   : received byte
//   clr         : return to P_IDLE, discard a coincident byte
//   make_stb    : key pressed, key_code valid this cycle
//   brk_stb     : key released, key_code valid this cycle
//   key_code    : key code belonging to the strobe
// Strobes are decoded from the registered prefix state and the incoming
// byte in the same cycle, so the allocator's output registers are the only
// stage between the completing byte and the channel outputs.
// ---------------------------------------------------------------------------
module ps2_code_parser
   import key_pkg::*;
#(
   parameter int TIMEOUT_CYC = 2_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       code_valid,
   input  logic [7:0] code_data,
   input  logic       clr,
   output logic       make_stb,
   output logic       brk_stb,
   output logic [7:0] key_code
);

   localparam int            TW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

   pstate_e       state;
   logic [TW-1:0] timer;

   assign key_code = code_data;

   always_comb begin
      make_stb = 1'b0;
      brk_stb  = 1'b0;
      if (code_valid && !clr) begin
         case (state)
            P_IDLE:  make_stb = (code_data != PFX_EXT) && (code_data != PFX_BRK) &&
                                !is_ignored(code_data);
            P_F0:    brk_stb  = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= P_IDLE;
         timer <= '0;
      end else if (clr) begin
         state <= P_IDLE;
         timer <= '0;
      end else if (code_valid) begin
         timer <= '0;
         case (state)
            P_IDLE: begin
               if (code_data == PFX_EXT)      state <= P_E0;
               else if (code_data == PFX_BRK) state <= P_F0;
               else                           state <= P_IDLE;
            end
            P_E0:    state <= (code_data == PFX_BRK) ? P_E0F0 : P_IDLE;
            default: state <= P_IDLE;
         endcase
      end else if (state != P_IDLE) begin
         // A prefix whose follow-up byte was lost must not swallow a later key.
         if (timer == TMAX) begin
            state <= P_IDLE;
            timer <= '0;
         end else begin
            timer <= timer + 1'b1;
         end
      end else begin
         timer <= '0;
      end
   end

endmodule

// File: rtl/key_channel_alloc.sv
// ---------------------------------------------------------------------------
// key_channel_alloc
// Polyphonic key allocator: assigns each held PS/2 key to one of four voice
// channels and drives the channel key codes to the note-lookup block.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : key_channel_alloc_if.slave (byte stream in, channel state out)
// Parameters:
//   STEAL_OLDEST : 1 = a make with all channels busy replaces the oldest channel
//   IDLE_CODE    : code driven on a free channel (decoded downstream as sound-off)
//   TIMEOUT_CYC  : cycles a prefix byte may wait for its follow-up byte
// All outputs are registered; each update lands one cycle after the
// code_valid of the byte that completes a make or break.
// ---------------------------------------------------------------------------
module key_channel_alloc
   import key_pkg::*;
#(
   parameter bit         STEAL_OLDEST = 1'b0,
   parameter logic [7:0] IDLE_CODE    = 8'hF0,
   parameter int         TIMEOUT_CYC  = 2_000_000
) (
   input logic                 clk,
   input logic                 rst_n,
   key_channel_alloc_if.slave  bus
);

   logic        make_stb;
   logic        brk_stb;
   logic [7:0]  key_code;

   logic [7:0]  code_q [NUM_CH];
   logic [1:0]  age_q  [NUM_CH];
   logic [NUM_CH-1:0] busy_q;
   logic        ovf_q;

   logic [7:0]  code_n [NUM_CH];
   logic [1:0]  age_n  [NUM_CH];
   logic [NUM_CH-1:0] busy_n;
   logic        ovf_n;

   logic [NUM_CH-1:0] hit_vec;
   logic        any_hit;
   logic        all_busy;
   logic [1:0]  free_idx;
   logic [1:0]  victim_idx;
   logic [1:0]  slot;
   logic        alloc;

   ps2_code_parser #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_parser (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_valid (bus.code_valid),
      .code_data  (bus.code_data),
      .clr        (bus.clr),
      .make_stb   (make_stb),
      .brk_stb    (brk_stb),
      .key_code   (key_code)
   );

   // Only busy channels take part in the lookup, so a free channel's
   // IDLE_CODE can never be matched by a break of that byte value.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         hit_vec[k] = busy_q[k] && (code_q[k] == key_code);
      end
   end

   assign any_hit  = |hit_vec;
   assign all_busy = &busy_q;

   // Lowest-index free channel.
   always_comb begin
      free_idx = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (!busy_q[k]) free_idx = 2'(k);
      end
   end

   // Oldest channel; strict compare keeps the lowest index on ties.
   always_comb begin
      victim_idx = '0;
      for (int k = 1; k < NUM_CH; k++) begin
         if (age_q[k] > age_q[victim_idx]) victim_idx = 2'(k);
      end
   end

   always_comb begin
      code_n = code_q;
      age_n  = age_q;
      busy_n = busy_q;
      ovf_n  = 1'b0;
      alloc  = 1'b0;
      slot   = free_idx;

      if (make_stb && !any_hit) begin
         if (!all_busy) begin
            alloc = 1'b1;
         end else begin
            ovf_n = 1'b1;
            if (STEAL_OLDEST) begin
               alloc = 1'b1;
               slot  = victim_idx;
            end
         end
      end

      if (alloc) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (slot == 2'(k)) begin
               code_n[k] = key_code;
               busy_n[k] = 1'b1;
               age_n[k]  = 2'd0;
            end else if (busy_q[k] && (age_q[k] != 2'd3)) begin
               age_n[k] = age_q[k] + 2'd1;
            end
         end
      end

      if (brk_stb) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (hit_vec[k]) begin
               code_n[k] = IDLE_CODE;
               busy_n[k] = 1'b0;
               age_n[k]  = 2'd0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_CH; k++) begin
            code_q[k] <= IDLE_CODE;
            age_q[k]  <= 2'd0;
         end
         busy_q <= '0;
         ovf_q  <= 1'b0;
      end else if (bus.clr) begin
         for (int k = 0; k < NUM_CH; k++) begin
            code_q[k] <= IDLE_CODE;
            age_q[k]  <= 2'd0;
         end
         busy_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         code_q <= code_n;
         age_q  <= age_n;
         busy_q <= busy_n;
         ovf_q  <= ovf_n;
      end
   end

   assign bus.scan_code1 = code_q[0];
   assign bus.scan_code2 = code_q[1];
   assign bus.scan_code3 = code_q[2];
   assign bus.scan_code4 = code_q[3];
   assign bus.busy_mask  = busy_q;
   assign bus.overflow   = ovf_q;

endmodule
